mtr_ramp_seq: RTL and testbench
===============================

# mtr_ramp_seq

Motor command sequencer feeding the left/right PWM motor driver. It converts two signed speed targets from the balance controller into per-side magnitude/direction pairs (`lft_spd`/`lft_rev`, `rght_spd`/`rght_rev`). Updates happen once per 2048-cycle PWM period. Each update is slew-limited, and every direction reversal follows the sequence decelerate → hold zero for a dead time → flip → accelerate, so the H-bridge is never commanded straight from one direction to the other. An enable input and a fault input force both sides to zero immediately.

## Interface
- `STEP`, 16: maximum change in magnitude per PWM period (11-bit units).
- `DEAD_TICKS`, 4: number of zero-speed periods held before a direction flip; must be ≥1.
- `PER_BITS`, 11: width of the period counter; period = 2^PER_BITS cycles, matching the PWM counter.
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: level enable; low forces both sides to zero.
- `flt` in 1: level fault (overcurrent); high forces both sides to zero.
- `lft_tgt` in 12: signed left target.
- `rght_tgt` in 12: signed right target.
- `lft_spd` out 11: left magnitude sent to the driver.
- `lft_rev` out 1: left reverse select.
- `rght_spd` out 11: right magnitude sent to the driver.
- `rght_rev` out 1: right reverse select.
- `lft_busy` out 1: left side is not in RUN, or its magnitude differs from the target magnitude.
- `rght_busy` out 1: same as `lft_busy`, for the right side.

## Operation
- Target decode, per side:
  - tdir = sign bit of the target.
  - tmag = |target|, with -2048 saturating to 2047.
  - If tmag == 0, the target is treated as matching the current direction (ramp down, no flip).
- Each side has an independent FSM with states RUN, DECEL and DEAD. All state, `mag`, `dir` and `dcnt` registers are per side.
- Period counter: free-running, width PER_BITS, 0 at reset. `tick` is asserted when the count equals 2^PER_BITS−1. All FSM and magnitude updates happen only on tick cycles, except the forced-zero path.
- RUN state, on tick:
  - If tdir == dir: `mag` moves toward tmag by at most STEP, without overshoot.
  - If tdir != dir: `mag` = max(`mag`−STEP, 0). If the result is 0, go to DEAD with `dcnt` = DEAD_TICKS; otherwise go to DECEL.
- DECEL state, on tick:
  - If tdir == dir again: return to RUN and apply the RUN ramp rule on the same tick (abort path).
  - Otherwise: `mag` = max(`mag`−STEP, 0). If the result is 0, go to DEAD with `dcnt` = DEAD_TICKS.
- DEAD state, on tick:
  - `mag` stays 0 and `dcnt` decrements.
  - When `dcnt` reaches 0, set `dir` to tdir and go to RUN. `mag` is still 0 on this tick; the ramp starts on the next tick.
  - If tdir == dir when the dead time expires, `dir` is unchanged.
- Forced zero (`en` == 0 or `flt` == 1), evaluated every cycle, not just on ticks:
  - On the next edge: `mag` = 0, state = DEAD, `dcnt` = DEAD_TICKS; `dir` is held.
  - While the condition persists, `dcnt` is reloaded every cycle.
  - After release, the normal DEAD countdown runs.
- Outputs: `*_spd` = `mag`, `*_rev` = `dir`, both taken directly from registers.

## Timing
- Reset values: all `*_spd` = 0, all `*_rev` = 0, all `*_busy` = 0, state RUN, period counter = 0, `dcnt` = 0.
- The first tick occurs at cycle 2047 after reset release. The update is visible from the next cycle, which is period-counter value 0. Outputs therefore change only at PWM period boundaries and stay glitch-free within a period.
- Latency from a target change to the first output change: 1 to 2048 cycles, depending on the phase of the period counter.
- Forced zero: outputs read 0 exactly one cycle after `en` falls or `flt` rises.
- Minimum reversal time from magnitude M: ceil(M/STEP) + DEAD_TICKS + ceil(|new|/STEP) ticks. `rev` toggles only while `spd` == 0.
- When a tick and a forced-zero condition coincide, forced zero wins.
- Targets are sampled only on tick cycles; changes between ticks are not tracked.

## Test plan
- Reset, then hold targets at 0 for 3 periods → all outputs stay 0 and `busy` = 0.
- `lft_tgt` = +100 → `lft_spd` takes values 16, 32, 48, 64, 80, 96, 100 at successive period boundaries; `lft_rev` = 0; `lft_busy` falls after 100 is reached.
- Reversal: at `lft_spd` = 40, set `lft_tgt` = −40 → `lft_spd` takes 24, 8, 0, then holds 0 for 4 periods. `lft_rev` goes to 1 on the 4th dead tick, then `lft_spd` takes 16, 32, 40.
- Abort: at `rght_spd` = 200, set target −50 for two ticks, then +300 → 184, 168, then 184, 200, … up to 300; `rght_rev` stays 0 and DEAD is never entered.
- Saturation: `lft_tgt` = −2048 from 0 → dead time first (4 zero ticks), `lft_rev` = 1, then `lft_spd` steps by 16 until it reaches 2047.
- Fault: pulse `flt` mid-ramp while `rght_spd` = 500 → `rght_spd` = 0 on the next cycle. After release, 4 zero ticks, then the ramp resumes from 16 with `rev` unchanged. Asserting `rst_n` low mid-ramp returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/mtr_ramp_if.sv
// rtl/mtr_ramp_if.sv - target/command bundle between the balance controller and the ramp sequencer
interface mtr_ramp_if;
    logic [11:0] lft_tgt;
    logic [11:0] rght_tgt;
    logic [10:0] lft_spd;
    logic        lft_rev;
    logic [10:0] rght_spd;
    logic        rght_rev;
    logic        lft_busy;
    logic        rght_busy;

    modport master (
        output lft_tgt, rght_tgt,
        input  lft_spd, lft_rev, rght_spd, rght_rev, lft_busy, rght_busy
    );

    modport slave (
        input  lft_tgt, rght_tgt,
        output lft_spd, lft_rev, rght_spd, rght_rev, lft_busy, rght_busy
    );
endinterface

// File: rtl/mtr_ramp_seq.sv
// rtl/mtr_ramp_seq.sv - per-side slew-limited motor command sequencer with dead-time reversal
module mtr_ramp_seq #(
    parameter int STEP       = 16,
    parameter int DEAD_TICKS = 4,
    parameter int PER_BITS   = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flt,
    mtr_ramp_if.slave    cmd
);
    typedef enum logic [1:0] {RUN, DECEL, DEAD} state_t;

    localparam int              DW      = $clog2(DEAD_TICKS + 1);
    localparam logic [10:0]     STEP_M  = 11'(STEP);
    localparam logic [DW-1:0]   DEAD_LD = DW'(DEAD_TICKS);

    logic [PER_BITS-1:0] per_cnt;
    logic                tick;
    logic                force_zero;

    // Index 0 is the left side, index 1 the right side.
    state_t      state_q [2];
    state_t      state_d [2];
    logic [10:0] mag_q   [2];
    logic [10:0] mag_d   [2];
    logic        dir_q   [2];
    logic        dir_d   [2];
    logic [DW-1:0] dcnt_q [2];
    logic [DW-1:0] dcnt_d [2];
    logic [11:0] tgt     [2];
    logic [10:0] tmag    [2];
    logic        tdir    [2];

    assign tick       = &per_cnt;
    assign force_zero = !en || flt;
    assign tgt[0]     = cmd.lft_tgt;
    assign tgt[1]     = cmd.rght_tgt;

    // A zero target adopts the current direction so it only ramps down.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            tdir[s] = tgt[s][11];
            tmag[s] = tgt[s][10:0];
            if (tgt[s] == 12'h800)
                tmag[s] = 11'h7FF;
            else if (tgt[s][11])
                tmag[s] = 11'(12'(-tgt[s]));
            if (tmag[s] == 11'd0)
                tdir[s] = dir_q[s];
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            mag_d[s]   = mag_q[s];
            dir_d[s]   = dir_q[s];
            dcnt_d[s]  = dcnt_q[s];
            if (force_zero) begin
                mag_d[s]   = 11'd0;
                state_d[s] = DEAD;
                dcnt_d[s]  = DEAD_LD;
            end else if (tick) begin
                case (state_q[s])
                    RUN, DECEL: begin
                        if (tdir[s] == dir_q[s]) begin
                            state_d[s] = RUN;
                            if (mag_q[s] < tmag[s])
                                mag_d[s] = (tmag[s] - mag_q[s] > STEP_M) ? mag_q[s] + STEP_M : tmag[s];
                            else
                                mag_d[s] = (mag_q[s] - tmag[s] > STEP_M) ? mag_q[s] - STEP_M : tmag[s];
                        end else if (mag_q[s] <= STEP_M) begin
                            mag_d[s]   = 11'd0;
                            state_d[s] = DEAD;
                            dcnt_d[s]  = DEAD_LD;
                        end else begin
                            mag_d[s]   = mag_q[s] - STEP_M;
                            state_d[s] = DECEL;
                        end
                    end
                    DEAD: begin
                        mag_d[s] = 11'd0;
                        if (dcnt_q[s] <= DW'(1)) begin
                            dcnt_d[s]  = '0;
                            dir_d[s]   = tdir[s];
                            state_d[s] = RUN;
                        end else begin
                            dcnt_d[s] = dcnt_q[s] - DW'(1);
                        end
                    end
                    default: state_d[s] = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= RUN;
                mag_q[s]   <= 11'd0;
                dir_q[s]   <= 1'b0;
                dcnt_q[s]  <= '0;
            end
        end else begin
            per_cnt <= per_cnt + 1'b1;
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                mag_q[s]   <= mag_d[s];
                dir_q[s]   <= dir_d[s];
                dcnt_q[s]  <= dcnt_d[s];
            end
        end
    end

    assign cmd.lft_spd   = mag_q[0];
    assign cmd.lft_rev   = dir_q[0];
    assign cmd.rght_spd  = mag_q[1];
    assign cmd.rght_rev  = dir_q[1];
    assign cmd.lft_busy  = (state_q[0] != RUN) || (mag_q[0] != tmag[0]);
    assign cmd.rght_busy = (state_q[1] != RUN) || (mag_q[1] != tmag[1]);
endmodule

// File: tb/tb_mtr_ramp_seq.sv
// tb/tb_mtr_ramp_seq.sv - directed bench for mtr_ramp_seq
module tb_mtr_ramp_seq;
    localparam int PER = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic flt;
    int   errors = 0;
    int   checks = 0;
    int   exp_v;

    mtr_ramp_if bus ();

    mtr_ramp_seq #(.STEP(16), .DEAD_TICKS(4), .PER_BITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .flt   (flt),
        .cmd   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic period();
        repeat (PER) @(posedge clk);
        #1;
    endtask

    task automatic chk_lft(input string tag, input int spd, input int rev);
        chk({tag, "_lspd"}, 32'(bus.lft_spd), 32'(spd));
        chk({tag, "_lrev"}, 32'(bus.lft_rev), 32'(rev));
    endtask

    task automatic chk_rght(input string tag, input int spd, input int rev);
        chk({tag, "_rspd"}, 32'(bus.rght_spd), 32'(spd));
        chk({tag, "_rrev"}, 32'(bus.rght_rev), 32'(rev));
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        flt = 1'b0;
        bus.lft_tgt = 12'd0;
        bus.rght_tgt = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_lft("reset", 0, 0);
        chk_rght("reset", 0, 0);
        chk("reset_lbusy", 32'(bus.lft_busy), 0);
        chk("reset_rbusy", 32'(bus.rght_busy), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) begin
            period();
            chk_lft("idle", 0, 0);
            chk_rght("idle", 0, 0);
            chk("idle_lbusy", 32'(bus.lft_busy), 0);
        end

        bus.lft_tgt = 12'd100;
        #1;
        chk("up_busy_on", 32'(bus.lft_busy), 1);
        for (int k = 1; k <= 7; k++) begin
            period();
            exp_v = (16 * k < 100) ? 16 * k : 100;
            chk_lft("up100", exp_v, 0);
        end
        chk("up_busy_off", 32'(bus.lft_busy), 0);

        bus.lft_tgt = 12'd40;
        for (int k = 1; k <= 4; k++) begin
            period();
            exp_v = (100 - 16 * k > 40) ? 100 - 16 * k : 40;
            chk_lft("down40", exp_v, 0);
        end

        bus.lft_tgt = -12'sd40;
        period(); chk_lft("rev_d1", 24, 0);
        period(); chk_lft("rev_d2", 8, 0);
        period(); chk_lft("rev_d3", 0, 0);
        chk("rev_dead_busy", 32'(bus.lft_busy), 1);
        for (int k = 0; k < 3; k++) begin
            period(); chk_lft("rev_hold", 0, 0);
        end
        period(); chk_lft("rev_flip", 0, 1);
        period(); chk_lft("rev_a1", 16, 1);
        period(); chk_lft("rev_a2", 32, 1);
        period(); chk_lft("rev_a3", 40, 1);

        bus.rght_tgt = 12'd200;
        for (int k = 1; k <= 13; k++) begin
            period();
            exp_v = (16 * k < 200) ? 16 * k : 200;
            chk_rght("r200", exp_v, 0);
        end
        bus.rght_tgt = -12'sd50;
        period(); chk_rght("abort_d1", 184, 0);
        period(); chk_rght("abort_d2", 168, 0);
        bus.rght_tgt = 12'd300;
        for (int k = 1; k <= 9; k++) begin
            period();
            exp_v = (168 + 16 * k < 300) ? 168 + 16 * k : 300;
            chk_rght("abort_up", exp_v, 0);
        end

        bus.rght_tgt = 12'd500;
        for (int k = 1; k <= 13; k++) begin
            period();
            exp_v = (300 + 16 * k < 500) ? 300 + 16 * k : 500;
            chk_rght("r500", exp_v, 0);
        end

        bus.rght_tgt = 12'd1000;
        repeat (10) @(posedge clk);
        #1;
        flt = 1'b1;
        @(posedge clk);
        #1;
        chk_rght("flt_zero", 0, 0);
        flt = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk_rght("flt_dead1", 0, 0);
        for (int k = 0; k < 3; k++) begin
            period(); chk_rght("flt_dead", 0, 0);
        end
        period(); chk_rght("flt_a1", 16, 0);
        period(); chk_rght("flt_a2", 32, 0);

        repeat (7) @(posedge clk);
        #1;
        bus.lft_tgt = 12'd0;
        bus.rght_tgt = 12'd0;
        rst_n = 1'b0;
        #1;
        chk_lft("async_rst", 0, 0);
        chk_rght("async_rst", 0, 0);
        chk("async_rst_lbusy", 32'(bus.lft_busy), 0);
        chk("async_rst_rbusy", 32'(bus.rght_busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        bus.lft_tgt = 12'h800;
        for (int k = 0; k < 4; k++) begin
            period(); chk_lft("sat_dead", 0, 0);
        end
        period(); chk_lft("sat_flip", 0, 1);
        for (int k = 1; k <= 128; k++) begin
            period();
            exp_v = (16 * k < 2047) ? 16 * k : 2047;
            chk_lft("sat_up", exp_v, 1);
        end
        chk("sat_busy_off", 32'(bus.lft_busy), 0);

        repeat (5) @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        chk_lft("en_off", 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
